// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  localparam int unsigned SUB_WIDTH_DEF = 4;

  // Bits needed to hold a value in [0, value-1].
  function automatic int unsigned clog2(input int unsigned value);
    return $clog2(value);
  endfunction

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Optional ovf signal is present only when SERIAL_SUB_OVF_EN is defined.
interface bit_serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif

endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Iterative subtractor computing a - b - bin one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow flag.
module bit_serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  bit_serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             out_valid;
  logic             bout;
  logic             d_bit;
  logic             b_bit;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .diff (d_bit),
    .bout (b_bit)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.diff      = res;
  assign bus.bout      = bout;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf;

  assign bus.ovf = ovf;

  // Operand sign bits are kept from the accept edge for the overflow decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      ovf   <= 1'b0;
    end else if (state == RUN && cnt == CNT_W'(WIDTH - 1)) begin
      ovf <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
    end
  end
`endif

  // Control FSM and serial datapath; result shifts in from the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      bout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= bus.bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          res  <= {d_bit, res[WIDTH-1:1]};
          br   <= b_bit;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bout      <= b_bit;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
